reg_if_arbiter: RTL

REG_IF_ARBITER -- requirements
Module: reg_if_arbiter

---
 rtl/reg_arb_pkg.sv | 15 +
 rtl/reg_arb_rr_pick.sv | 26 ++
 rtl/reg_if_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-requester register-interface arbiter.
//   NUM_REQ     : number of requesters sharing the register port
//   CNT_W       : width of the busy/timeout counter
//   arb_state_e : arbiter FSM state encoding
package reg_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } arb_state_e;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Round-robin winner selection between two requesters.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the requester granted most recently
//   win_o   : index of the selected requester (valid only when valid_o)
//   valid_o : at least one request is present
module reg_arb_rr_pick
  import reg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic               win_o,
  output logic               valid_o
);

  always_comb begin
    valid_o = |req_i;
    // On a tie the requester that did not win last time goes first;
    // otherwise the lone requester wins.
    if (req_i == 2'b11) begin
      win_o = ~last_i;
    end else begin
      win_o = req_i[1];
    end
  end

endmodule

// File: rtl/reg_if_arbiter.sv
// Arbitrates two bus requesters onto a single register interface.
//   clk, rst_n          : clock and asynchronous active-low reset
//   req_dv/write/addr/wdata : per-requester transfer request and payload
//   req_hld/err/rdata   : per-requester wait, error and read data
//   reg_we/re/addr/wdata/be : register-side access strobes and payload
//   reg_rdata/error/busy: register-side response
//   timeout_pulse       : one-cycle pulse when an access is forced to end
module reg_if_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_dv,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_hld,
  output logic [1:0]              req_err,
  output logic [2*DATA_WIDTH-1:0] req_rdata,
  output logic                    reg_we,
  output logic                    reg_re,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_be,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_error,
  input  logic                    reg_busy,
  output logic                    timeout_pulse
);

  // Timeout fires on the busy cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic pick_win;
  logic pick_valid;
  logic timeout;
  logic complete;

  reg_arb_rr_pick u_rr_pick (
    .req_i   (req_dv),
    .last_i  (grant_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  assign reg_be = '1;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    reg_addr      = '0;
    reg_wdata     = '0;
    req_hld       = req_dv;
    req_err       = '0;
    req_rdata     = '0;
    timeout_pulse = 1'b0;
    timeout       = 1'b0;
    complete      = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StAccess;
          grant_d = pick_win;
          write_d = req_write[pick_win];
          addr_d  = req_addr[int'(pick_win)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(pick_win)*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = '0;
        end
      end
      StAccess: begin
        reg_addr  = addr_q;
        reg_wdata = wdata_q;
        if (reg_busy) begin
          cnt_d   = cnt_q + 8'd1;
          timeout = (cnt_q == TmoLast);
        end
        complete      = ~reg_busy | timeout;
        reg_we        = write_q & ~timeout;
        reg_re        = ~write_q & ~timeout;
        timeout_pulse = timeout;
        if (complete) begin
          state_d          = StIdle;
          req_hld[grant_q] = 1'b0;
          // A requester that already dropped dv gets no result.
          if (req_dv[grant_q]) begin
            req_err[grant_q] = timeout | reg_error;
            req_rdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = reg_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
